// File: rtl/sram_port_arb.sv
// rtl/sram_port_arb.sv - single-port SRAM arbiter: load writes vs buffer/store reads
// Round-robin among three requesters; a multi-beat load burst locks out the readers.
module sram_port_arb #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 128,
  parameter int RR_INIT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_req_vld,
  input  logic [ADDR_W-1:0] ld_req_addr,
  input  logic [DATA_W-1:0] ld_req_data,
  input  logic              ld_req_last,
  output logic              ld_req_rdy,
  input  logic              buf_req_vld,
  input  logic [ADDR_W-1:0] buf_req_addr,
  output logic              buf_req_rdy,
  input  logic              st_req_vld,
  input  logic [ADDR_W-1:0] st_req_addr,
  output logic              st_req_rdy,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              buf_rsp_vld,
  output logic [ADDR_W-1:0] buf_rsp_addr,
  output logic [DATA_W-1:0] buf_rsp_data,
  output logic              st_rsp_vld,
  output logic [ADDR_W-1:0] st_rsp_addr,
  output logic [DATA_W-1:0] st_rsp_data,
  output logic              arb_lock
);

  typedef enum logic {
    ARB   = 1'b0,
    WLOCK = 1'b1
  } state_t;

  localparam logic [1:0] RR_INIT_V = 2'(RR_INIT);

  state_t            state_q, state_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              gnt_ld, gnt_buf, gnt_st;
  logic              rd_vld_q, rd_own_st_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              run;

  // rst_n is active-high despite its name; run is the not-in-reset qualifier.
  assign run = ~rst_n;

  always_comb begin
    gnt_ld   = 1'b0;
    gnt_buf  = 1'b0;
    gnt_st   = 1'b0;
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    if (run) begin
      case (state_q)
        ARB: begin
          case (rr_ptr_q)
            2'd1: begin
              if (buf_req_vld)     gnt_buf = 1'b1;
              else if (st_req_vld) gnt_st  = 1'b1;
              else if (ld_req_vld) gnt_ld  = 1'b1;
            end
            2'd2: begin
              if (st_req_vld)       gnt_st  = 1'b1;
              else if (ld_req_vld)  gnt_ld  = 1'b1;
              else if (buf_req_vld) gnt_buf = 1'b1;
            end
            default: begin
              if (ld_req_vld)       gnt_ld  = 1'b1;
              else if (buf_req_vld) gnt_buf = 1'b1;
              else if (st_req_vld)  gnt_st  = 1'b1;
            end
          endcase
          if (gnt_ld) begin
            rr_ptr_d = 2'd1;
            if (!ld_req_last) state_d = WLOCK;
          end else if (gnt_buf) begin
            rr_ptr_d = 2'd2;
          end else if (gnt_st) begin
            rr_ptr_d = 2'd0;
          end
        end
        WLOCK: begin
          // Readers stay blocked even while the loader idles between beats.
          gnt_ld = ld_req_vld;
          if (gnt_ld && ld_req_last) begin
            state_d  = ARB;
            rr_ptr_d = 2'd1;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  assign ld_req_rdy  = gnt_ld;
  assign buf_req_rdy = gnt_buf;
  assign st_req_rdy  = gnt_st;
  assign mem_cen     = gnt_ld | gnt_buf | gnt_st;
  assign mem_wen     = gnt_ld;
  assign mem_din     = gnt_ld ? ld_req_data : '0;
  assign arb_lock    = run && (state_q == WLOCK);

  always_comb begin
    mem_addr = '0;
    if (gnt_ld)       mem_addr = ld_req_addr;
    else if (gnt_buf) mem_addr = buf_req_addr;
    else if (gnt_st)  mem_addr = st_req_addr;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= ARB;
      rr_ptr_q    <= RR_INIT_V;
      rd_vld_q    <= 1'b0;
      rd_own_st_q <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rd_vld_q    <= gnt_buf | gnt_st;
      rd_own_st_q <= gnt_st;
      if (gnt_buf)     rd_addr_q <= buf_req_addr;
      else if (gnt_st) rd_addr_q <= st_req_addr;
    end
  end

  // Read data is steered straight from the macro; only the owner sees it.
  assign buf_rsp_vld  = run && rd_vld_q && !rd_own_st_q;
  assign st_rsp_vld   = run && rd_vld_q && rd_own_st_q;
  assign buf_rsp_addr = buf_rsp_vld ? rd_addr_q : '0;
  assign st_rsp_addr  = st_rsp_vld ? rd_addr_q : '0;
  assign buf_rsp_data = buf_rsp_vld ? mem_dout : '0;
  assign st_rsp_data  = st_rsp_vld ? mem_dout : '0;

endmodule

// File: tb/tb_sram_port_arb.sv
// tb/tb_sram_port_arb.sv - directed and random checks of sram_port_arb against a reference model
module tb_sram_port_arb;
  localparam int AW  = 8;
  localparam int DW  = 128;
  localparam int RRI = 0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ld_req_vld = 1'b0;
  logic [AW-1:0] ld_req_addr = '0;
  logic [DW-1:0] ld_req_data = '0;
  logic          ld_req_last = 1'b0;
  logic          ld_req_rdy;
  logic          buf_req_vld = 1'b0;
  logic [AW-1:0] buf_req_addr = '0;
  logic          buf_req_rdy;
  logic          st_req_vld = 1'b0;
  logic [AW-1:0] st_req_addr = '0;
  logic          st_req_rdy;
  logic          mem_cen, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic          buf_rsp_vld, st_rsp_vld, arb_lock;
  logic [AW-1:0] buf_rsp_addr, st_rsp_addr;
  logic [DW-1:0] buf_rsp_data, st_rsp_data;

  sram_port_arb #(.ADDR_W(AW), .DATA_W(DW), .RR_INIT(RRI)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req_vld(ld_req_vld), .ld_req_addr(ld_req_addr), .ld_req_data(ld_req_data),
    .ld_req_last(ld_req_last), .ld_req_rdy(ld_req_rdy),
    .buf_req_vld(buf_req_vld), .buf_req_addr(buf_req_addr), .buf_req_rdy(buf_req_rdy),
    .st_req_vld(st_req_vld), .st_req_addr(st_req_addr), .st_req_rdy(st_req_rdy),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout),
    .buf_rsp_vld(buf_rsp_vld), .buf_rsp_addr(buf_rsp_addr), .buf_rsp_data(buf_rsp_data),
    .st_rsp_vld(st_rsp_vld), .st_rsp_addr(st_rsp_addr), .st_rsp_data(st_rsp_data),
    .arb_lock(arb_lock)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] sram    [256];
  logic [DW-1:0] ref_mem [256];

  always @(posedge clk) begin
    if (mem_cen) begin
      if (mem_wen) sram[mem_addr] <= mem_din;
      else         mem_dout <= sram[mem_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  int            m_ptr = RRI;
  bit            m_lock = 1'b0;
  bit            m_pv = 1'b0;
  int            m_po = 0;
  logic [AW-1:0] m_pa = '0;
  int            last_win = -1;

  function automatic logic [DW-1:0] pat(input int a);
    logic [7:0] b;
    b = a[7:0] ^ 8'hA5;
    return {16{b}};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit vld_of(input int r);
    if (r == 0) return ld_req_vld;
    if (r == 1) return buf_req_vld;
    return st_req_vld;
  endfunction

  task automatic cycle();
    int            w;
    bit            in_rst, eb, es;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    @(negedge clk);
    in_rst = rst_n;
    w = -1;
    if (!in_rst) begin
      if (m_lock) begin
        if (ld_req_vld) w = 0;
      end else begin
        for (int k = 0; k < 3; k++)
          if (w < 0 && vld_of((m_ptr + k) % 3)) w = (m_ptr + k) % 3;
      end
    end
    e_addr = (w == 0) ? ld_req_addr : (w == 1) ? buf_req_addr : (w == 2) ? st_req_addr : '0;
    e_din  = (w == 0) ? ld_req_data : '0;
    eb = !in_rst && m_pv && (m_po == 1);
    es = !in_rst && m_pv && (m_po == 2);
    chk("ld_rdy", ld_req_rdy, w == 0);
    chk("buf_rdy", buf_req_rdy, w == 1);
    chk("st_rdy", st_req_rdy, w == 2);
    chk("mem_cen", mem_cen, w >= 0);
    chk("mem_wen", mem_wen, w == 0);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_din", mem_din, e_din);
    chk("arb_lock", arb_lock, !in_rst && m_lock);
    chk("buf_rsp_vld", buf_rsp_vld, eb);
    chk("st_rsp_vld", st_rsp_vld, es);
    chk("buf_rsp_data", buf_rsp_data, eb ? ref_mem[m_pa] : '0);
    chk("st_rsp_data", st_rsp_data, es ? ref_mem[m_pa] : '0);
    if (eb || in_rst) chk("buf_rsp_addr", buf_rsp_addr, eb ? m_pa : '0);
    if (es || in_rst) chk("st_rsp_addr", st_rsp_addr, es ? m_pa : '0);
    last_win = w;
    if (in_rst) begin
      m_ptr = RRI; m_lock = 1'b0; m_pv = 1'b0;
    end else begin
      m_pv = (w == 1) || (w == 2);
      m_po = w;
      if (m_pv) m_pa = e_addr;
      if (w == 0) ref_mem[ld_req_addr] = ld_req_data;
      if (m_lock) begin
        if (w == 0 && ld_req_last) begin m_lock = 1'b0; m_ptr = 1; end
      end else if (w >= 0) begin
        m_ptr = (w + 1) % 3;
        if (w == 0 && !ld_req_last) m_lock = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit            ld_act, buf_act, st_act;
    int            ld_left, ld_beat, beat;
    logic [AW-1:0] ld_base;
    logic [DW-1:0] wdata;
    for (int i = 0; i < 256; i++) begin
      sram[i] = pat(i);
      ref_mem[i] = pat(i);
    end

    // reset with every requester asking
    rst_n = 1'b1; ld_req_vld = 1'b1; buf_req_vld = 1'b1; st_req_vld = 1'b1;
    cycle();
    chk("rst_rdy", {ld_req_rdy, buf_req_rdy, st_req_rdy}, 3'b000);
    chk("rst_cen", mem_cen, 1'b0);
    cycle();
    rst_n = 1'b0; ld_req_vld = 1'b0; buf_req_vld = 1'b0; st_req_vld = 1'b0;

    // single read
    buf_req_vld = 1'b1; buf_req_addr = 8'h12;
    #1;
    chk("sr_rdy", buf_req_rdy, 1'b1);
    chk("sr_addr", mem_addr, 8'h12);
    chk("sr_wen", mem_wen, 1'b0);
    cycle();
    buf_req_vld = 1'b0;
    #1;
    chk("sr_rsp_vld", buf_rsp_vld, 1'b1);
    chk("sr_rsp_addr", buf_rsp_addr, 8'h12);
    chk("sr_rsp_data", buf_rsp_data, pat(8'h12));
    chk("sr_st_vld", st_rsp_vld, 1'b0);
    cycle();

    // round robin with all three requesting, single-beat writes
    rst_n = 1'b1;
    cycle();
    rst_n = 1'b0;
    ld_req_vld = 1'b1; buf_req_vld = 1'b1; st_req_vld = 1'b1; ld_req_last = 1'b1;
    buf_req_addr = 8'h33; st_req_addr = 8'h44;
    for (int i = 0; i < 6; i++) begin
      if (i % 3 == 0) begin
        ld_req_addr = 8'(8'h80 + i);
        ld_req_data = {$urandom, $urandom, $urandom, $urandom};
      end
      #1;
      chk("rr_ld", ld_req_rdy, i % 3 == 0);
      chk("rr_buf", buf_req_rdy, i % 3 == 1);
      chk("rr_st", st_req_rdy, i % 3 == 2);
      chk("rr_wen", mem_wen, i % 3 == 0);
      chk("rr_bufrsp", buf_rsp_vld, i % 3 == 2);
      chk("rr_strsp", st_rsp_vld, i == 3);
      cycle();
    end
    ld_req_vld = 1'b0; buf_req_vld = 1'b0; st_req_vld = 1'b0;
    cycle();

    // four-beat burst with a two-cycle gap while BUF waits
    buf_req_vld = 1'b1; buf_req_addr = 8'h40;
    beat = 0;
    for (int i = 0; i < 7; i++) begin
      ld_req_vld = (i < 6) && (i != 2) && (i != 3);
      if (ld_req_vld) begin
        ld_req_addr = 8'(8'h20 + beat);
        ld_req_data = {$urandom, $urandom, $urandom, $urandom};
        ld_req_last = (beat == 3);
      end
      #1;
      chk("bl_lock", arb_lock, (i >= 1) && (i <= 5));
      chk("bl_buf", buf_req_rdy, i == 6);
      chk("bl_ld", ld_req_rdy, ld_req_vld);
      cycle();
      if (ld_req_vld) beat++;
    end
    ld_req_vld = 1'b0; buf_req_vld = 1'b0;
    cycle();

    // back-to-back store reads
    for (int i = 0; i < 4; i++) begin
      st_req_vld = (i < 3);
      st_req_addr = 8'(i);
      #1;
      chk("b2b_vld", st_rsp_vld, i > 0);
      if (i > 0) chk("b2b_addr", st_rsp_addr, 8'(i - 1));
      cycle();
    end
    st_req_vld = 1'b0;

    // reset in the middle of a locked burst
    buf_req_vld = 1'b1; buf_req_addr = 8'h55;
    ld_req_vld = 1'b1; ld_req_addr = 8'h30; ld_req_last = 1'b0;
    ld_req_data = {$urandom, $urandom, $urandom, $urandom};
    #1;
    chk("mr_beat1", ld_req_rdy, 1'b1);
    cycle();
    ld_req_addr = 8'h31;
    cycle();
    rst_n = 1'b1; ld_req_addr = 8'h32;
    #1;
    chk("mr_lock", arb_lock, 1'b0);
    chk("mr_cen", mem_cen, 1'b0);
    chk("mr_bufrdy", buf_req_rdy, 1'b0);
    cycle();
    rst_n = 1'b0; ld_req_vld = 1'b0;
    #1;
    chk("mr_buf_after", buf_req_rdy, 1'b1);
    cycle();
    buf_req_vld = 1'b0; rst_n = 1'b1;
    #1;
    chk("mr_inflight", buf_rsp_vld, 1'b0);
    cycle();
    rst_n = 1'b0;
    #1;
    chk("mr_dropped", buf_rsp_vld, 1'b0);
    cycle();

    // top address, written then read back
    wdata = {$urandom, $urandom, $urandom, $urandom};
    ld_req_vld = 1'b1; ld_req_addr = 8'hFF; ld_req_data = wdata; ld_req_last = 1'b1;
    cycle();
    ld_req_vld = 1'b0; buf_req_vld = 1'b1; buf_req_addr = 8'hFF;
    cycle();
    buf_req_vld = 1'b0;
    #1;
    chk("wrap_addr", buf_rsp_addr, 8'hFF);
    chk("wrap_data", buf_rsp_data, wdata);
    cycle();

    // idle
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_cen", mem_cen, 1'b0);
      chk("idle_addr", mem_addr, '0);
      cycle();
    end

    // random traffic with occasional resets
    ld_act = 1'b0; buf_act = 1'b0; st_act = 1'b0;
    ld_left = 0; ld_beat = 0; ld_base = '0;
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 59) == 0);
      if (!ld_act && $urandom_range(0, 2) != 0) begin
        if (ld_left == 0) begin
          ld_left = $urandom_range(1, 4);
          ld_beat = 0;
          ld_base = 8'($urandom);
        end
        ld_act = 1'b1;
        ld_req_addr = ld_base + 8'(ld_beat);
        ld_req_data = {$urandom, $urandom, $urandom, $urandom};
        ld_req_last = (ld_left == 1);
      end
      ld_req_vld = ld_act;
      if (!buf_act && $urandom_range(0, 1) == 1) begin
        buf_act = 1'b1;
        buf_req_addr = 8'($urandom);
      end
      buf_req_vld = buf_act;
      if (!st_act && $urandom_range(0, 1) == 1) begin
        st_act = 1'b1;
        st_req_addr = 8'($urandom);
      end
      st_req_vld = st_act;
      cycle();
      if (rst_n) begin
        ld_act = 1'b0; buf_act = 1'b0; st_act = 1'b0; ld_left = 0;
      end else begin
        case (last_win)
          0: begin ld_act = 1'b0; ld_left--; ld_beat++; end
          1: buf_act = 1'b0;
          2: st_act = 1'b0;
          default: ;
        endcase
      end
      ld_req_vld = ld_act; buf_req_vld = buf_act; st_req_vld = st_act;
    end
    rst_n = 1'b0; ld_req_vld = 1'b0; buf_req_vld = 1'b0; st_req_vld = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
